// File: rtl/gpr_fwd_scoreboard.sv
// ID-stage operand bypass with a one-entry multi-cycle scoreboard and hazard stall.
// Optional stall counter output enabled by defining GPR_FWD_STALL_CNT_EN.
module gpr_fwd_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [RD_PORTS*ADDR_W-1:0]   id_raddr,
    input  logic [RD_PORTS*DATA_W-1:0]   id_rdata,
    input  logic [RD_PORTS-1:0]          id_rused,
    input  logic                         id_we,
    input  logic [ADDR_W-1:0]            id_waddr,
    input  logic                         id_mc_issue,
    input  logic                         exe_we,
    input  logic [ADDR_W-1:0]            exe_waddr,
    input  logic [DATA_W-1:0]            exe_wdata,
    input  logic                         exe_is_load,
    input  logic                         mem_we,
    input  logic [ADDR_W-1:0]            mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mc_done,
    input  logic [DATA_W-1:0]            mc_wdata,
    output logic [RD_PORTS*DATA_W-1:0]   fwd_rdata,
    output logic                         stall,
    output logic                         mc_busy
`ifdef GPR_FWD_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} sb_state_e;

    sb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pend_q, pend_d;

    logic              busy_open;
    logic              load_use, mc_raw, mc_waw, mc_struct;
    logic              accept;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              exe_hit, mem_hit, mc_hit;

    // An entry still blocks readers/writers only until its completion cycle.
    assign busy_open = (state_q == BUSY) && !mc_done;

    always_comb begin
        fwd_rdata = '0;
        load_use  = 1'b0;
        mc_raw    = 1'b0;
        ra        = '0;
        rd        = '0;
        exe_hit   = 1'b0;
        mem_hit   = 1'b0;
        mc_hit    = 1'b0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            ra      = id_raddr[p*ADDR_W +: ADDR_W];
            rd      = id_rdata[p*DATA_W +: DATA_W];
            exe_hit = exe_we && (ra == exe_waddr);
            mem_hit = mem_we && (ra == mem_waddr);
            mc_hit  = (state_q == BUSY) && mc_done && (ra == pend_q);
            // An EXE load match blocks the MEM path; the stall covers its value.
            if (ra == '0)
                fwd_rdata[p*DATA_W +: DATA_W] = rd;
            else if (exe_hit)
                fwd_rdata[p*DATA_W +: DATA_W] = exe_wdata;
            else if (mem_hit)
                fwd_rdata[p*DATA_W +: DATA_W] = mem_wdata;
            else if (mc_hit)
                fwd_rdata[p*DATA_W +: DATA_W] = mc_wdata;
            else
                fwd_rdata[p*DATA_W +: DATA_W] = rd;
            if (id_rused[p] && (ra != '0)) begin
                if (exe_hit && exe_is_load)
                    load_use = 1'b1;
                if (busy_open && (ra == pend_q))
                    mc_raw = 1'b1;
            end
        end
    end

    assign mc_waw    = busy_open && id_we && (id_waddr == pend_q);
    assign mc_struct = busy_open && id_mc_issue;
    assign stall     = !rst && id_valid && (load_use || mc_raw || mc_waw || mc_struct);
    assign accept    = id_valid && id_mc_issue && !stall && (id_waddr != '0);
    assign mc_busy   = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    pend_d  = id_waddr;
                end
            end
            BUSY: begin
                if (mc_done) begin
                    if (accept) begin
                        state_d = BUSY;
                        pend_d  = id_waddr;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

`ifdef GPR_FWD_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1))
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gpr_fwd_scoreboard.sv
// Directed self-checking bench for gpr_fwd_scoreboard (default parameters).
module tb_gpr_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_raddr;
    logic [63:0] id_rdata;
    logic [1:0]  id_rused;
    logic        id_we;
    logic [4:0]  id_waddr;
    logic        id_mc_issue;
    logic        exe_we;
    logic [4:0]  exe_waddr;
    logic [31:0] exe_wdata;
    logic        exe_is_load;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mc_done;
    logic [31:0] mc_wdata;
    logic [63:0] fwd_rdata;
    logic        stall;
    logic        mc_busy;
`ifdef GPR_FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gpr_fwd_scoreboard #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .RD_PORTS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_raddr   (id_raddr),
        .id_rdata   (id_rdata),
        .id_rused   (id_rused),
        .id_we      (id_we),
        .id_waddr   (id_waddr),
        .id_mc_issue(id_mc_issue),
        .exe_we     (exe_we),
        .exe_waddr  (exe_waddr),
        .exe_wdata  (exe_wdata),
        .exe_is_load(exe_is_load),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mc_done    (mc_done),
        .mc_wdata   (mc_wdata),
        .fwd_rdata  (fwd_rdata),
        .stall      (stall),
        .mc_busy    (mc_busy)
`ifdef GPR_FWD_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid    = 1'b0;
        id_raddr    = '0;
        id_rdata    = '0;
        id_rused    = '0;
        id_we       = 1'b0;
        id_waddr    = '0;
        id_mc_issue = 1'b0;
        exe_we      = 1'b0;
        exe_waddr   = '0;
        exe_wdata   = '0;
        exe_is_load = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        mc_done     = 1'b0;
        mc_wdata    = '0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Load-use hazard presented during reset must not stall
        id_valid    = 1'b1;
        id_raddr    = {5'd7, 5'd5};
        id_rused    = 2'b11;
        id_rdata    = {32'h0000_0077, 32'h0000_0055};
        exe_we      = 1'b1;
        exe_waddr   = 5'd7;
        exe_is_load = 1'b1;
        exe_wdata   = 32'hDEAD_0007;
        mem_we      = 1'b1;
        mem_waddr   = 5'd5;
        mem_wdata   = 32'h5555_AAAA;
        #1;
        check("rst_busy", {31'd0, mc_busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_fwd0", fwd_rdata[31:0], 32'h5555_AAAA);
        tick();
        rst = 1'b0;
        clear_inputs();

        // EXE over MEM priority
        id_valid  = 1'b1;
        id_raddr  = {5'd0, 5'd5};
        id_rused  = 2'b01;
        id_rdata  = {32'h0, 32'h1111_1111};
        exe_we    = 1'b1; exe_waddr = 5'd5; exe_wdata = 32'hAAAA_0001;
        mem_we    = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'hBBBB_0002;
        #1;
        check("exe_prio", fwd_rdata[31:0], 32'hAAAA_0001);
        check("exe_prio_stall", {31'd0, stall}, 32'd0);
        exe_we = 1'b0;
        #1;
        check("mem_fwd", fwd_rdata[31:0], 32'hBBBB_0002);
        mem_we = 1'b0;
        #1;
        check("rf_fwd", fwd_rdata[31:0], 32'h1111_1111);

        // Zero register never forwarded
        id_raddr  = {5'd0, 5'd0};
        id_rused  = 2'b11;
        id_rdata  = '0;
        exe_we    = 1'b1; exe_waddr = 5'd0; exe_wdata = 32'h1234_5678; exe_is_load = 1'b1;
        mem_we    = 1'b1; mem_waddr = 5'd0; mem_wdata = 32'h1234_5678;
        mc_done   = 1'b1; mc_wdata  = 32'h1234_5678;
        #1;
        check("r0_fwd0", fwd_rdata[31:0], 32'h0);
        check("r0_fwd1", fwd_rdata[63:32], 32'h0);
        check("r0_stall", {31'd0, stall}, 32'd0);
        clear_inputs();

        // Load-use
        id_valid    = 1'b1;
        id_raddr    = {5'd7, 5'd3};
        id_rused    = 2'b11;
        id_rdata    = {32'h0000_0700, 32'h0000_0300};
        exe_we      = 1'b1; exe_waddr = 5'd7; exe_is_load = 1'b1; exe_wdata = 32'h0;
        #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        exe_we      = 1'b0; exe_is_load = 1'b0;
        mem_we      = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'hCAFE_F00D;
        #1;
        check("lu_mem_fwd", fwd_rdata[63:32], 32'hCAFE_F00D);
        check("lu_release", {31'd0, stall}, 32'd0);
        mem_we      = 1'b0;
        exe_we      = 1'b1; exe_is_load = 1'b1;
        id_rused    = 2'b01;
        #1;
        check("lu_unused", {31'd0, stall}, 32'd0);
        clear_inputs();

        // Multi-cycle RAW
        id_valid    = 1'b1;
        id_mc_issue = 1'b1; id_we = 1'b1; id_waddr = 5'd9;
        #1;
        check("mc_issue_stall", {31'd0, stall}, 32'd0);
        check("mc_pre_busy", {31'd0, mc_busy}, 32'd0);
        tick();
        id_mc_issue = 1'b0; id_we = 1'b0; id_waddr = 5'd0;
        id_raddr    = {5'd0, 5'd9};
        id_rused    = 2'b01;
        id_rdata    = {32'h0, 32'h9999_9999};
        #1;
        check("mc_busy_set", {31'd0, mc_busy}, 32'd1);
        check("mc_raw_stall", {31'd0, stall}, 32'd1);
        tick();
        tick();
        check("mc_raw_held", {31'd0, stall}, 32'd1);
        mc_done  = 1'b1;
        mc_wdata = 32'h0000_0042;
        #1;
        check("mc_done_fwd", fwd_rdata[31:0], 32'h0000_0042);
        check("mc_done_stall", {31'd0, stall}, 32'd0);
        tick();
        mc_done = 1'b0;
        #1;
        check("mc_busy_clr", {31'd0, mc_busy}, 32'd0);
        clear_inputs();

        // WAW, structural, done+issue handoff
        id_valid    = 1'b1;
        id_mc_issue = 1'b1; id_we = 1'b1; id_waddr = 5'd9;
        tick();
        id_mc_issue = 1'b0;
        #1;
        check("waw_stall", {31'd0, stall}, 32'd1);
        id_we       = 1'b0; id_mc_issue = 1'b1; id_waddr = 5'd12;
        #1;
        check("struct_stall", {31'd0, stall}, 32'd1);
        id_we       = 1'b1; id_waddr = 5'd10; mc_done = 1'b1; mc_wdata = 32'h0000_0099;
        #1;
        check("handoff_stall", {31'd0, stall}, 32'd0);
        tick();
        clear_inputs();
        id_valid = 1'b1;
        id_raddr = {5'd0, 5'd10};
        id_rused = 2'b01;
        #1;
        check("handoff_busy", {31'd0, mc_busy}, 32'd1);
        check("pend10_raw", {31'd0, stall}, 32'd1);
        id_raddr = {5'd0, 5'd9};
        #1;
        check("pend9_free", {31'd0, stall}, 32'd0);

        // Reset mid-BUSY drops the entry
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, mc_busy}, 32'd0);
        tick();
        rst      = 1'b0;
        id_raddr = {5'd0, 5'd10};
        id_rdata = {32'h0, 32'h7777_7777};
        mc_done  = 1'b1;
        mc_wdata = 32'h0000_0055;
        #1;
        check("late_done_fwd", fwd_rdata[31:0], 32'h7777_7777);
        check("late_done_stall", {31'd0, stall}, 32'd0);
        tick();
        check("late_done_busy", {31'd0, mc_busy}, 32'd0);
        clear_inputs();

`ifdef GPR_FWD_STALL_CNT_EN
        rst = 1'b1;
        #1;
        check("cnt_rst", stall_cnt, 32'd0);
        tick();
        rst         = 1'b0;
        id_valid    = 1'b1;
        id_raddr    = {5'd0, 5'd4};
        id_rused    = 2'b01;
        exe_we      = 1'b1; exe_waddr = 5'd4; exe_is_load = 1'b1;
        tick();
        tick();
        tick();
        clear_inputs();
        #1;
        check("cnt_three", stall_cnt, 32'd3);
        rst = 1'b1;
        #1;
        check("cnt_clr", stall_cnt, 32'd0);
        tick();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
